rail_fence_enc: RTL and testbench

Rail-fence encryption stage that sits directly upstream of the rail-fence decryptor. It produces the terminated ciphertext byte stream that the decryptor consumes on its data input. The block buffers one plaintext message, ending with the terminator byte, then replays it in zig-zag rail order at one byte per clock. The same rail count, key, is used on both sides of the link.

---
 rtl/rail_fence_enc.sv | 164 ++++++++++++++++
 tb/tb_rail_fence_enc.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rail_fence_enc.sv
// Rail-fence encryptor: buffers one TERM-terminated plaintext message, then
// replays it in zig-zag rail order at one byte per clock, followed by TERM.
module rail_fence_enc #(
   parameter int unsigned MAX_LEN = 50,
   parameter logic [7:0]  TERM    = 8'hFA
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data,
   input  logic       valid_i,
   input  logic [1:0] key,
   output logic [7:0] data_e,
   output logic       valid_e,
   output logic       last_e,
   output logic       busy,
   output logic       ovf
);

   localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1);
   localparam int unsigned ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   // One spare bit so idx + step can never wrap past len.
   localparam int unsigned IDX_W  = LEN_W + 1;

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_EMIT    = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   len, len_nxt;
   logic [LEN_W-1:0]   cnt, cnt_nxt;
   logic [1:0]         n, n_nxt;
   logic [1:0]         rail, rail_nxt;
   logic               phase, phase_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [7:0]         data_e_nxt;
   logic               valid_e_nxt, last_e_nxt, busy_nxt, ovf_nxt;
   logic               we_c;
   logic [IDX_W-1:0]   period_c, rail2_c, step_c, idx_sum_c;

   logic [7:0] mem [MAX_LEN];

   // Payload buffer; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (we_c) mem[len[ADDR_W-1:0]] <= data;
   end

   // Zig-zag step: boundary rails use the full period, middle rails alternate.
   always_comb begin
      period_c = IDX_W'({n, 1'b0}) - IDX_W'(2);
      rail2_c  = IDX_W'({rail, 1'b0});
      if (n == 2'd1)
         step_c = IDX_W'(1);
      else if ((rail == 2'd0) || (rail == (n - 2'd1)))
         step_c = period_c;
      else if (!phase)
         step_c = period_c - rail2_c;
      else
         step_c = rail2_c;
      idx_sum_c = idx + step_c;
   end

   always_comb begin
      state_nxt   = state;
      len_nxt     = len;
      cnt_nxt     = cnt;
      n_nxt       = n;
      rail_nxt    = rail;
      phase_nxt   = phase;
      idx_nxt     = idx;
      ovf_nxt     = ovf;
      busy_nxt    = busy;
      data_e_nxt  = 8'h00;
      valid_e_nxt = 1'b0;
      last_e_nxt  = 1'b0;
      we_c        = 1'b0;

      case (state)
         S_COLLECT: begin
            if (valid_i) begin
               if (data == TERM) begin
                  state_nxt = S_EMIT;
                  busy_nxt  = 1'b1;
                  rail_nxt  = 2'd0;
                  idx_nxt   = '0;
                  phase_nxt = 1'b0;
                  cnt_nxt   = '0;
                  if (len == '0) n_nxt = 2'd1;
               end else if (len < LEN_W'(MAX_LEN)) begin
                  we_c    = 1'b1;
                  len_nxt = len + LEN_W'(1);
                  if (len == '0) begin
                     n_nxt   = (key < 2'd2) ? 2'd1 : key;
                     ovf_nxt = 1'b0;
                  end
               end else begin
                  ovf_nxt = 1'b1;
               end
            end
         end

         S_EMIT: begin
            valid_e_nxt = 1'b1;
            if (cnt == len) begin
               data_e_nxt = TERM;
               last_e_nxt = 1'b1;
               state_nxt  = S_DONE;
            end else begin
               data_e_nxt = mem[idx[ADDR_W-1:0]];
               cnt_nxt    = cnt + LEN_W'(1);
               // Past the end of this rail: restart at the next rail's head.
               if (idx_sum_c >= {1'b0, len}) begin
                  rail_nxt  = rail + 2'd1;
                  idx_nxt   = IDX_W'(rail) + IDX_W'(1);
                  phase_nxt = 1'b0;
               end else begin
                  idx_nxt   = idx_sum_c;
                  phase_nxt = ~phase;
               end
            end
         end

         S_DONE: begin
            busy_nxt  = 1'b0;
            len_nxt   = '0;
            state_nxt = S_COLLECT;
         end

         default: state_nxt = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_COLLECT;
         len     <= '0;
         cnt     <= '0;
         n       <= 2'd1;
         rail    <= 2'd0;
         phase   <= 1'b0;
         idx     <= '0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         data_e  <= 8'h00;
         valid_e <= 1'b0;
         last_e  <= 1'b0;
      end else begin
         state   <= state_nxt;
         len     <= len_nxt;
         cnt     <= cnt_nxt;
         n       <= n_nxt;
         rail    <= rail_nxt;
         phase   <= phase_nxt;
         idx     <= idx_nxt;
         ovf     <= ovf_nxt;
         busy    <= busy_nxt;
         data_e  <= data_e_nxt;
         valid_e <= valid_e_nxt;
         last_e  <= last_e_nxt;
      end
   end

endmodule

// File: tb/tb_rail_fence_enc.sv
// Self-checking bench for rail_fence_enc: fixed vectors, corner sequences and
// random messages checked against a rail-assignment reference model.
module tb_rail_fence_enc;

   localparam int         MAX_LEN = 50;
   localparam logic [7:0] TERM    = 8'hFA;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data;
   logic       valid_i;
   logic [1:0] key;
   logic [7:0] data_e;
   logic       valid_e, last_e, busy, ovf;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] pt_q [$];
   logic [7:0] exp_q [$];

   rail_fence_enc #(.MAX_LEN(MAX_LEN), .TERM(TERM)) dut (
      .clk(clk), .reset(reset), .data(data), .valid_i(valid_i), .key(key),
      .data_e(data_e), .valid_e(valid_e), .last_e(last_e), .busy(busy), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]   key;
      logic [1:0]   key_mid;
      logic [7:0]   len;
      logic [127:0] pt;   // right-justified, first byte most significant
      logic [135:0] ct;   // ciphertext followed by TERM
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Reference: each index i sits on rail f(i mod period) of the zig-zag;
   // ciphertext is the plaintext stably sorted by rail.
   task automatic build_exp(input logic [1:0] k);
      int nr, p, len, m, rl;
      exp_q.delete();
      nr  = (k < 2'd2) ? 1 : int'(k);
      len = (pt_q.size() > MAX_LEN) ? MAX_LEN : pt_q.size();
      if (nr == 1) begin
         for (int i = 0; i < len; i++) exp_q.push_back(pt_q[i]);
      end else begin
         p = 2 * (nr - 1);
         for (int r = 0; r < nr; r++)
            for (int i = 0; i < len; i++) begin
               m  = i % p;
               rl = (m < nr) ? m : p - m;
               if (rl == r) exp_q.push_back(pt_q[i]);
            end
      end
      exp_q.push_back(TERM);
   endtask

   // Drives pt_q then TERM; returns #1 after the edge that sampled TERM.
   task automatic send_bytes(input logic [1:0] k0, input logic [1:0] k1);
      for (int i = 0; i < pt_q.size(); i++) begin
         data = pt_q[i]; key = (i == 0) ? k0 : k1; valid_i = 1'b1;
         @(posedge clk); #1;
      end
      data = TERM; key = k1; valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
   endtask

   // Expects exp_q gap-free on the edges after TERM, then an idle cycle.
   task automatic check_emit(input string nm, input bit junk);
      for (int j = 0; j < exp_q.size(); j++) begin
         valid_i = junk; data = 8'($urandom); key = 2'($urandom);
         @(posedge clk); #1;
         chk($sformatf("%s byte%0d", nm, j), {5'd0, busy, valid_e, last_e, data_e},
             {5'd0, 1'b1, 1'b1, 1'(j == exp_q.size() - 1), exp_q[j]});
      end
      valid_i = junk; data = TERM;
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk({nm, " idle"}, {5'd0, busy, valid_e, last_e, data_e}, 16'd0);
   endtask

   initial begin
      logic [7:0] b;
      int len, k, km;

      vecs[0] = '{2'd2, 2'd2, 8'd9, 128'h444349545445525041, 136'h444954524143544550FA};
      vecs[1] = '{2'd3, 2'd3, 8'd9, 128'h444349545445525041, 136'h445441435445504952FA};
      vecs[2] = '{2'd0, 2'd0, 8'd3, 128'h414243,             136'h414243FA};
      vecs[3] = '{2'd1, 2'd1, 8'd3, 128'h414243,             136'h414243FA};
      vecs[4] = '{2'd2, 2'd2, 8'd0, 128'h0,                  136'hFA};
      vecs[5] = '{2'd3, 2'd3, 8'd2, 128'h4142,               136'h4142FA};
      vecs[6] = '{2'd3, 2'd2, 8'd9, 128'h444349545445525041, 136'h445441435445504952FA};

      reset = 1'b1; valid_i = 1'b0; data = 8'h00; key = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset state", {4'd0, busy, valid_e, last_e, ovf, data_e}, 16'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Fixed vectors, with junk driven while busy.
      for (int v = 0; v < 7; v++) begin
         len = int'(vecs[v].len);
         pt_q.delete(); exp_q.delete();
         for (int i = 0; i < len; i++) pt_q.push_back(vecs[v].pt[8*(len-1-i) +: 8]);
         for (int j = 0; j <= len; j++) exp_q.push_back(vecs[v].ct[8*(len-j) +: 8]);
         send_bytes(vecs[v].key, vecs[v].key_mid);
         chk($sformatf("vec%0d busy at TERM", v), {15'd0, busy}, 16'd1);
         check_emit($sformatf("vec%0d", v), 1'b1);
      end

      // Overflow: MAX_LEN+3 bytes, truncated but still terminated.
      pt_q.delete();
      for (int i = 0; i < MAX_LEN + 3; i++) pt_q.push_back(8'(i + 1));
      build_exp(2'd3);
      send_bytes(2'd3, 2'd3);
      chk("ovf set", {15'd0, ovf}, 16'd1);
      check_emit("ovf msg", 1'b0);
      chk("ovf sticky", {15'd0, ovf}, 16'd1);
      pt_q.delete();
      pt_q.push_back(8'h41); pt_q.push_back(8'h42); pt_q.push_back(8'h43);
      build_exp(2'd2);
      send_bytes(2'd2, 2'd2);
      chk("ovf cleared", {15'd0, ovf}, 16'd0);
      check_emit("post ovf", 1'b0);

      // Reset in the middle of EMIT.
      pt_q.delete();
      for (int i = 0; i < 8; i++) pt_q.push_back(8'(8'h30 + i));
      send_bytes(2'd2, 2'd2);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("mid-emit reset", {4'd0, busy, valid_e, last_e, ovf, data_e}, 16'd0);
      @(posedge clk); #1;
      chk("after reset idle", {5'd0, busy, valid_e, last_e, data_e}, 16'd0);
      pt_q.delete();
      for (int i = 0; i < 7; i++) pt_q.push_back(8'(8'h61 + i));
      build_exp(2'd3);
      send_bytes(2'd3, 2'd1);
      check_emit("post reset", 1'b0);

      // Random messages against the reference model.
      for (int it = 0; it < 25; it++) begin
         k   = $urandom_range(0, 3);
         km  = $urandom_range(0, 3);
         len = (it % 3 == 0) ? $urandom_range(0, MAX_LEN) : $urandom_range(0, 8);
         pt_q.delete();
         for (int i = 0; i < len; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == TERM);
            pt_q.push_back(b);
         end
         build_exp(2'(k));
         send_bytes(2'(k), 2'(km));
         check_emit($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
